// File: rtl/mem_loader.sv
// Byte-serial loader: assembles little-endian 32-bit words and writes them to consecutive addresses from 0.
// Latency: write strobe one cycle after the 4th byte of a word is accepted; done coincides with the final write.
// Backpressure: in_ready is high only while loading; bytes offered in IDLE or DONE are left unconsumed.
module mem_loader #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4:0]        len,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [4:0]        word_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] MAX_WORDS = 5'(DEPTH);

    state_t              state_q, state_d;
    logic [4:0]          target_q, target_d;
    logic [4:0]          word_count_q, word_count_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [23:0]         asm_q, asm_d;
    logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [4:0]          len_clamped;

    assign len_clamped = (len > MAX_WORDS) ? MAX_WORDS : len;

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        word_count_d = word_count_q;
        byte_idx_d   = byte_idx_q;
        asm_d        = asm_q;
        addr_cnt_d   = addr_cnt_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    target_d     = len_clamped;
                    word_count_d = 5'd0;
                    byte_idx_d   = 2'd0;
                    asm_d        = 24'd0;
                    addr_cnt_d   = '0;
                    state_d      = (len_clamped == 5'd0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                // in_ready is high throughout LOAD, so in_valid alone means a byte is taken
                if (in_valid) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: asm_d[7:0]   = in_byte;
                        2'd1: asm_d[15:8]  = in_byte;
                        2'd2: asm_d[23:16] = in_byte;
                        default: begin
                            wr_en_d      = 1'b1;
                            wr_addr_d    = addr_cnt_q;
                            wr_data_d    = {in_byte, asm_q};
                            addr_cnt_d   = addr_cnt_q + 1'b1;
                            word_count_d = word_count_q + 5'd1;
                            if (word_count_q + 5'd1 == target_q) begin
                                state_d = DONE;
                            end
                        end
                    endcase
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            target_q     <= 5'd0;
            word_count_q <= 5'd0;
            byte_idx_q   <= 2'd0;
            asm_q        <= 24'd0;
            addr_cnt_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            word_count_q <= word_count_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            addr_cnt_q   <= addr_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign in_ready   = (state_q == LOAD);
    assign busy       = (state_q == LOAD);
    assign done       = (state_q == DONE);
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_mem_loader.sv
// Testbench for mem_loader: per-scenario tasks drive the byte stream and push expected writes to a
// scoreboard queue; a negedge monitor pops and compares every write strobe.
module tb_mem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  len;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [4:0]  word_count;

    typedef struct {
        logic        last;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [4:0]  wc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   wr_cnt   = 0;
    int   done_cnt = 0;

    mem_loader #(.ADDR_W(4), .DEPTH(16), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (wr_en) begin
            wr_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", wr_addr, wr_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({done, wr_addr, wr_data, word_count} !== {e.last, e.addr, e.data, e.wc})
                    $display("FAIL write: got done=%b addr=%0d data=%h wc=%0d, expected done=%b addr=%0d data=%h wc=%0d",
                             done, wr_addr, wr_data, word_count, e.last, e.addr, e.data, e.wc);
                else
                    n_pass++;
            end
        end
    end

    task automatic push_word(input int k, input int target, input logic [31:0] data);
        exp_t e;
        e.last = (k + 1 == target);
        e.addr = 4'(k);
        e.data = data;
        e.wc   = 5'(k + 1);
        exp_q.push_back(e);
    endtask

    task automatic do_start(input logic [4:0] l);
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offers one byte after 'gap' idle cycles; returns at posedge+1 after it was accepted
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic acc;
        int   budget;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_byte  = b;
        acc      = 1'b0;
        budget   = 50;
        while (!acc && budget > 0) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            budget--;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            $display("FAIL byte_timeout: byte %h not accepted within 50 cycles, in_ready=%b", b, in_ready);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_byte  = 8'hA5;
        idle_cycles(2);
        @(negedge clk);
        n_checks++;
        if ({in_ready, wr_en, wr_addr, wr_data, busy, done, word_count} !== 44'd0)
            $display("FAIL reset_outputs: got rdy=%b wr_en=%b addr=%0d data=%h busy=%b done=%b wc=%0d, expected all 0",
                     in_ready, wr_en, wr_addr, wr_data, busy, done, word_count);
        else n_pass++;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        idle_cycles(2);
        n_checks++;
        if (wr_cnt !== 0) $display("FAIL reset_no_write: got %0d writes, expected 0", wr_cnt);
        else n_pass++;
    endtask

    task automatic test_single_word();
        int w0, d0;
        w0 = wr_cnt; d0 = done_cnt;
        push_word(0, 1, 32'h11223344);
        do_start(5'd1);
        @(negedge clk);
        n_checks++;
        if ({in_ready, busy} !== 2'b11) $display("FAIL single_ready: got rdy=%b busy=%b, expected 1 1", in_ready, busy);
        else n_pass++;
        @(posedge clk); #1;
        // start was accepted one edge ago; first byte goes in on the next edge
        send_byte(8'h44, 0);
        send_byte(8'h33, 0);
        send_byte(8'h22, 0);
        send_byte(8'h11, 0);
        idle_cycles(3);
        n_checks++;
        if ({wr_cnt - w0, done_cnt - d0} !== {32'd1, 32'd1})
            $display("FAIL single_counts: got writes=%0d dones=%0d, expected 1 1", wr_cnt - w0, done_cnt - d0);
        else n_pass++;
        n_checks++;
        if ({in_ready, word_count, wr_addr, wr_data} !== {1'b0, 5'd1, 4'd0, 32'h11223344})
            $display("FAIL single_after: got rdy=%b wc=%0d addr=%0d data=%h, expected 0 1 0 11223344",
                     in_ready, word_count, wr_addr, wr_data);
        else n_pass++;
    endtask

    task automatic test_full_fill_gaps();
        int w0, d0;
        w0 = wr_cnt; d0 = done_cnt;
        for (int k = 0; k < 16; k++)
            push_word(k, 16, {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
        do_start(5'd16);
        for (int i = 0; i < 64; i++) begin
            if (i == 21) start = 1'b1;
            if (i == 22) start = 1'b0;
            len = 5'd2;
            send_byte(8'(i), int'($urandom_range(0, 2)));
        end
        start = 1'b0;
        idle_cycles(3);
        n_checks++;
        if ({wr_cnt - w0, done_cnt - d0} !== {32'd16, 32'd1})
            $display("FAIL full_counts: got writes=%0d dones=%0d, expected 16 1", wr_cnt - w0, done_cnt - d0);
        else n_pass++;
        n_checks++;
        if ({busy, word_count, exp_q.size()} !== {1'b0, 5'd16, 32'd0})
            $display("FAIL full_after: got busy=%b wc=%0d pending=%0d, expected 0 16 0", busy, word_count, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_clamp_and_zero();
        int w0, d0;
        w0 = wr_cnt; d0 = done_cnt;
        for (int k = 0; k < 16; k++)
            push_word(k, 16, {8'(4*k+3) ^ 8'h5A, 8'(4*k+2) ^ 8'h5A, 8'(4*k+1) ^ 8'h5A, 8'(4*k) ^ 8'h5A});
        do_start(5'd20);
        for (int i = 0; i < 64; i++) send_byte(8'(i) ^ 8'h5A, 0);
        idle_cycles(3);
        n_checks++;
        if ({wr_cnt - w0, done_cnt - d0, word_count} !== {32'd16, 32'd1, 5'd16})
            $display("FAIL clamp_counts: got writes=%0d dones=%0d wc=%0d, expected 16 1 16",
                     wr_cnt - w0, done_cnt - d0, word_count);
        else n_pass++;
        w0 = wr_cnt; d0 = done_cnt;
        do_start(5'd0);
        @(negedge clk);
        n_checks++;
        if ({done, busy, in_ready, word_count} !== {1'b1, 1'b0, 1'b0, 5'd0})
            $display("FAIL zero_done: got done=%b busy=%b rdy=%b wc=%0d, expected 1 0 0 0", done, busy, in_ready, word_count);
        else n_pass++;
        @(posedge clk); #1;
        idle_cycles(3);
        n_checks++;
        if ({wr_cnt - w0, done_cnt - d0} !== {32'd0, 32'd1})
            $display("FAIL zero_counts: got writes=%0d dones=%0d, expected 0 1", wr_cnt - w0, done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_reset_mid_word();
        int w0;
        w0 = wr_cnt;
        for (int k = 0; k < 3; k++)
            push_word(k, 8, {8'(4*k+3) | 8'h80, 8'(4*k+2) | 8'h80, 8'(4*k+1) | 8'h80, 8'(4*k) | 8'h80});
        do_start(5'd8);
        for (int i = 0; i < 14; i++) send_byte(8'(i) | 8'h80, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({wr_en, word_count, in_ready, busy, wr_addr, wr_data} !== 44'd0)
            $display("FAIL midreset_outputs: got wr_en=%b wc=%0d rdy=%b busy=%b addr=%0d data=%h, expected all 0",
                     wr_en, word_count, in_ready, busy, wr_addr, wr_data);
        else n_pass++;
        @(posedge clk); #1;
        idle_cycles(2);
        n_checks++;
        if ({wr_cnt - w0, exp_q.size()} !== {32'd3, 32'd0})
            $display("FAIL midreset_writes: got writes=%0d pending=%0d, expected 3 0", wr_cnt - w0, exp_q.size());
        else n_pass++;
        push_word(0, 1, 32'hDEADBEEF);
        do_start(5'd1);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 1);
        send_byte(8'hAD, 0);
        send_byte(8'hDE, 0);
        idle_cycles(3);
        n_checks++;
        if ({wr_cnt - w0, word_count, exp_q.size()} !== {32'd4, 5'd1, 32'd0})
            $display("FAIL midreset_reload: got writes=%0d wc=%0d pending=%0d, expected 4 1 0",
                     wr_cnt - w0, word_count, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int w0;
        w0 = wr_cnt;
        in_valid = 1'b1;
        in_byte  = 8'hEE;
        idle_cycles(5);
        @(negedge clk);
        n_checks++;
        if ({in_ready, wr_en} !== 2'b00) $display("FAIL bp_idle: got rdy=%b wr_en=%b, expected 0 0", in_ready, wr_en);
        else n_pass++;
        @(posedge clk); #1;
        do_start(5'd0);
        @(negedge clk);
        n_checks++;
        if ({done, in_ready} !== 2'b10) $display("FAIL bp_done: got done=%b rdy=%b, expected 1 0", done, in_ready);
        else n_pass++;
        @(posedge clk); #1;
        idle_cycles(2);
        push_word(0, 1, 32'h04030201);
        do_start(5'd1);
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 0);
        idle_cycles(3);
        n_checks++;
        if ({wr_cnt - w0, exp_q.size()} !== {32'd1, 32'd0})
            $display("FAIL bp_counts: got writes=%0d pending=%0d, expected 1 0", wr_cnt - w0, exp_q.size());
        else n_pass++;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        len      = 5'd0;
        in_byte  = 8'd0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_single_word();
        test_full_fill_gaps();
        test_clamp_and_zero();
        test_reset_mid_word();
        test_backpressure();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
# mem_loader

Sequential writer that fills the 16-word, 32-bit operand/result memory of the Jericalla datapath from a byte-serial stream. It accepts bytes over a valid/ready handshake, assembles them little-endian into 32-bit words, and issues one write per completed word to consecutive addresses starting at 0. It sits between an external byte source (test host or UART front end) and the memory's write port, and replaces file-based preloading of memory contents.

## Interface
- ADDR_W, 4, memory address width
- DEPTH, 16, number of memory words; equals 2**ADDR_W
- DATA_W, 32, memory word width; 4 bytes per word
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  one-cycle request to begin a load; sampled only in IDLE
- len  input  5  number of words to load, latched on accepted start
- in_byte  input  8  stream byte
- in_valid  input  1  in_byte is valid
- in_ready  output  1  loader accepts a byte this cycle
- wr_en  output  1  memory write strobe, one cycle per word
- wr_addr  output  ADDR_W  write address
- wr_data  output  DATA_W  write data
- busy  output  1  high in LOAD state
- done  output  1  one-cycle pulse at load completion
- word_count  output  5  words written since last accepted start

## Operation
- Reset values: state IDLE; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, word_count=0; byte index and assembly register cleared.
- States: IDLE, LOAD, DONE.
- IDLE: in_ready=0. On start=1: latch target = min(len,16), clear word_count, byte index=0, address counter=0. If target=0, go DONE (no writes); else go LOAD.
- LOAD: in_ready=1, busy=1. Byte accepted when in_valid & in_ready. Byte index i (0..3) places in_byte at bits [8i+7:8i] of the assembly register; index increments and wraps 3->0.
- Byte with index 3 completes a word: on that edge, register wr_en=1, wr_addr=address counter, wr_data={in_byte, bytes 2,1,0}; increment address counter and word_count.
- If that word makes word_count equal target: go DONE on the same edge. Else stay in LOAD.
- DONE: done=1, in_ready=0, busy=0 for exactly one cycle; then IDLE.
- start is ignored in LOAD and DONE.
- Address counter is ADDR_W bits; at target=16 the last write goes to 15 and the counter wraps to 0, unused afterwards.
- in_valid while in_ready=0: byte not consumed, no state change.
- Reset mid-load: partial word discarded, no write issued, all outputs return to reset values on the next edge.

## Timing
- in_ready is a registered state decode; it is high from the first cycle after start is accepted.
- Throughput: one byte per cycle; a word every 4 accepted bytes; no stall cycles between words.
- Write latency: wr_en is high in the cycle immediately after the edge that accepted byte 3; wr_addr and wr_data are valid in that same cycle; wr_en lasts exactly one cycle.
- Final word: wr_en and done are high in the same cycle; word_count already equals target in that cycle.
- Zero-length load: done high in the cycle after start, no wr_en.
- wr_addr and wr_data hold their last values while wr_en=0.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with in_valid=1 -> all outputs 0, in_ready=0, no wr_en.
- Single word: start with len=1, then bytes 0x44,0x33,0x22,0x11 on consecutive cycles -> one wr_en with wr_addr=0, wr_data=0x11223344; done pulses in the same cycle; word_count=1; in_ready=0 afterwards.
- Full fill with gaps: len=16, 64 bytes with random in_valid gaps, word k = {4k+3,4k+2,4k+1,4k} -> 16 writes to addresses 0..15 with matching data; done pulses once; start during LOAD ignored.
- Clamp and zero length: len=20 -> exactly 16 writes; len=0 -> done one cycle after start, no writes.
- Reset mid-word: after 2 bytes of word 3, rst_n=0 for one cycle -> no write at addr 3, word_count=0; a new load with len=1 writes to address 0.
- Back-pressure: in_valid=1 held in IDLE and DONE -> no bytes consumed, no wr_en.
